// File: rtl/adc_lane_align.sv
`default_nettype none
// ============================================================================
// Module  : adc_lane_align
// Brief   : Frame-pattern bitslip aligner and 1/2-lane sample assembler for
//           serial-LVDS ADCs, with optional test-pattern error counting.
// Revision: 1.0 - initial release
// ============================================================================
module adc_lane_align #(
  parameter int              NCH       = 4,
  parameter int              LANES     = 2,
  parameter int              DW        = 8,
  parameter int              SW        = 14,
  parameter logic [DW-1:0]   FRAME_PAT = 8'h0f,
  parameter int              LOCK_CNT  = 16,
  parameter int              SLIP_WAIT = 7
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [DW-1:0]             fr_word,
  input  logic [NCH*LANES*DW-1:0]   lane_word,
  input  logic                      align_start,
  input  logic                      pattern_check_en,
  input  logic [SW-1:0]             testpattern,
  input  logic                      err_clr,
  output logic                      bitslip,
  output logic                      locked,
  output logic                      align_fail,
  output logic [$clog2(DW+1)-1:0]   slip_count,
  output logic [NCH*SW-1:0]         adc_out,
  output logic                      adc_valid,
  output logic [15:0]               err_count,
  output logic                      pattern_ok
);

  localparam int LW  = LANES * DW;
  localparam int SCW = $clog2(DW + 1);
  localparam int GCW = $clog2(LOCK_CNT + 1);
  localparam int WCW = $clog2(SLIP_WAIT + 1);
  localparam logic [SCW-1:0] SLIP_MAX  = SCW'(DW);
  localparam logic [GCW-1:0] GOOD_LAST = GCW'(LOCK_CNT - 1);
  localparam logic [WCW-1:0] WAIT_LAST = WCW'(SLIP_WAIT - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CHECK  = 3'd1,
    S_SLIP   = 3'd2,
    S_WAIT   = 3'd3,
    S_LOCKED = 3'd4,
    S_FAIL   = 3'd5
  } state_t;

  state_t          state, state_nxt;
  logic [SCW-1:0]  slip_nxt;
  logic [GCW-1:0]  good_cnt, good_nxt;
  logic [WCW-1:0]  wait_cnt, wait_nxt;
  logic            frame_ok;
  logic            mismatch;
  logic [NCH*SW-1:0] sample;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      slip_count <= '0;
      good_cnt   <= '0;
      wait_cnt   <= '0;
    end else begin
      state      <= state_nxt;
      slip_count <= slip_nxt;
      good_cnt   <= good_nxt;
      wait_cnt   <= wait_nxt;
    end
  end

  assign frame_ok = (fr_word == FRAME_PAT);

  // align_start overrides every state, including suppressing a pending slip pulse
  always_comb begin
    state_nxt = state;
    slip_nxt  = slip_count;
    good_nxt  = good_cnt;
    wait_nxt  = wait_cnt;
    bitslip   = 1'b0;
    if (align_start) begin
      state_nxt = S_CHECK;
      slip_nxt  = '0;
      good_nxt  = '0;
      wait_nxt  = '0;
    end else begin
      case (state)
        S_IDLE: ;
        S_CHECK: begin
          if (frame_ok) begin
            good_nxt = good_cnt + 1'b1;
            if (good_cnt == GOOD_LAST) state_nxt = S_LOCKED;
          end else if (slip_count == SLIP_MAX) begin
            state_nxt = S_FAIL;
          end else begin
            state_nxt = S_SLIP;
            good_nxt  = '0;
          end
        end
        S_SLIP: begin
          bitslip   = 1'b1;
          slip_nxt  = slip_count + 1'b1;
          wait_nxt  = '0;
          state_nxt = S_WAIT;
        end
        S_WAIT: begin
          if (wait_cnt == WAIT_LAST) state_nxt = S_CHECK;
          else                       wait_nxt  = wait_cnt + 1'b1;
        end
        S_LOCKED: begin
          if (!frame_ok) begin
            state_nxt = S_CHECK;
            slip_nxt  = '0;
            good_nxt  = '0;
          end
        end
        S_FAIL: ;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  assign locked     = (state == S_LOCKED);
  assign align_fail = (state == S_FAIL);

  // Sample bit i is F[LW-SW+i]; in 2-lane mode odd F bits come from lane a, even from lane b
  for (genvar c = 0; c < NCH; c++) begin : g_ch
    for (genvar i = 0; i < SW; i++) begin : g_bit
      localparam int P = LW - SW + i;
      if (LANES == 2) begin : g_two
        if (P % 2 == 1) begin : g_a
          assign sample[c*SW+i] = lane_word[(c*LANES)*DW + P/2];
        end else begin : g_b
          assign sample[c*SW+i] = lane_word[(c*LANES+1)*DW + P/2];
        end
      end else begin : g_one
        assign sample[c*SW+i] = lane_word[c*LANES*DW + P];
      end
    end
  end

  always_comb begin
    mismatch = 1'b0;
    for (int c = 0; c < NCH; c++) begin
      if (adc_out[c*SW +: SW] != testpattern) mismatch = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      adc_out    <= '0;
      adc_valid  <= 1'b0;
      err_count  <= '0;
      pattern_ok <= 1'b1;
    end else begin
      adc_out   <= sample;
      adc_valid <= locked;
      if (err_clr)
        err_count <= '0;
      else if (pattern_check_en && adc_valid && mismatch && err_count != 16'hffff)
        err_count <= err_count + 16'd1;
      if (pattern_check_en && adc_valid) pattern_ok <= !mismatch;
    end
  end

endmodule
`default_nettype wire
